// File: rtl/e_mul_pkg.sv
// Shared types for the e-series multiplier scheduler.
package e_mul_pkg;
  localparam int WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    START,
    WAIT,
    DRAIN
  } sched_state_e;
endpackage

// File: rtl/e_mul_sched_rr_arb.sv
// Combinational round-robin pick: first set request at or after rr_ptr, cyclically.
module e_rr_arb #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] rr_ptr,
  output logic [NREQ-1:0]         pick,
  output logic [$clog2(NREQ)-1:0] pick_idx
);
  localparam int IW = $clog2(NREQ);

  logic [IW-1:0] cand;

  // Scan from the farthest offset down so the nearest request wins.
  always_comb begin
    pick_idx = '0;
    cand     = '0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      cand = IW'((int'(rr_ptr) + off) % NREQ);
      if (req[cand]) pick_idx = cand;
    end
    pick           = '0;
    pick[pick_idx] = |req;
  end
endmodule

// File: rtl/e_mul_sched.sv
// Round-robin scheduler that feeds one shared multi-word multiplier and
// streams its product back to the granted client.
module e_mul_sched
  import e_mul_pkg::*;
#(
  parameter int WORDS   = 32,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NREQ-1:0]              req,
  output logic [NREQ-1:0]              gnt,
  input  logic [NREQ-1:0]              in_valid,
  input  logic [NREQ-1:0][WORD_W-1:0]  in_data,
  output logic [NREQ-1:0]              in_ready,
  output logic                         mul_start,
  output logic [WORDS-1:0][WORD_W-1:0] mul_a,
  output logic [WORDS-1:0][WORD_W-1:0] mul_b,
  input  logic                         mul_done,
  input  logic [WORDS-1:0][WORD_W-1:0] mul_product,
  output logic                         out_valid,
  output logic [WORD_W-1:0]            out_data,
  output logic                         out_last,
  output logic [$clog2(NREQ)-1:0]      out_id,
  input  logic                         out_ready,
  output logic                         busy,
  output logic                         err
);
  localparam int CW = $clog2(WORDS);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int IW = $clog2(NREQ);

  sched_state_e                 state_reg, state_next;
  logic [CW-1:0]                cnt_reg;
  logic [TW-1:0]                tmo_reg;
  logic [NREQ-1:0]              gnt_reg;
  logic [IW-1:0]                id_reg;
  logic [IW-1:0]                rr_ptr_reg;
  logic                         err_reg;
  logic [WORDS-1:0][WORD_W-1:0] a_reg, b_reg;

  logic [NREQ-1:0] arb_pick;
  logic [IW-1:0]   arb_idx;
  logic [IW-1:0]   ptr_after;
  logic            loading, load_fire, drain_fire, cnt_end, tmo_hit;

  e_rr_arb #(.NREQ(NREQ)) u_arb (
    .req     (req),
    .rr_ptr  (rr_ptr_reg),
    .pick    (arb_pick),
    .pick_idx(arb_idx)
  );

  assign loading    = (state_reg == LOAD_A) || (state_reg == LOAD_B);
  assign load_fire  = loading && in_valid[id_reg];
  assign drain_fire = (state_reg == DRAIN) && out_ready;
  assign cnt_end    = (cnt_reg == CW'(WORDS - 1));
  assign tmo_hit    = (state_reg == WAIT) && !mul_done && (tmo_reg == TW'(TIMEOUT - 1));
  assign ptr_after  = IW'((int'(id_reg) + 1) % NREQ);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (|req) state_next = LOAD_A;
      LOAD_A:  if (load_fire && cnt_end) state_next = LOAD_B;
      LOAD_B:  if (load_fire && cnt_end) state_next = START;
      START:   state_next = WAIT;
      WAIT: begin
        if (mul_done)     state_next = DRAIN;
        else if (tmo_hit) state_next = IDLE;
      end
      DRAIN:   if (drain_fire && cnt_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg    <= '0;
      tmo_reg    <= '0;
      gnt_reg    <= '0;
      id_reg     <= '0;
      rr_ptr_reg <= '0;
      err_reg    <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|req) begin
            gnt_reg <= arb_pick;
            id_reg  <= arb_idx;
            cnt_reg <= '0;
          end
        end
        LOAD_A, LOAD_B: begin
          if (load_fire) begin
            if (state_reg == LOAD_A) a_reg[cnt_reg] <= in_data[id_reg];
            else                     b_reg[cnt_reg] <= in_data[id_reg];
            cnt_reg <= cnt_end ? '0 : cnt_reg + 1'b1;
          end
        end
        START: tmo_reg <= '0;
        WAIT: begin
          if (mul_done) begin
            cnt_reg <= '0;
          end else if (tmo_hit) begin
            // Abandon the job silently; the error flag stays until reset.
            err_reg    <= 1'b1;
            gnt_reg    <= '0;
            rr_ptr_reg <= ptr_after;
          end else begin
            tmo_reg <= tmo_reg + 1'b1;
          end
        end
        DRAIN: begin
          if (drain_fire) begin
            if (cnt_end) begin
              cnt_reg    <= '0;
              gnt_reg    <= '0;
              rr_ptr_reg <= ptr_after;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
    assign in_ready[gi] = gnt_reg[gi] & loading;
  end

  assign gnt       = gnt_reg;
  assign mul_start = (state_reg == START);
  assign mul_a     = a_reg;
  assign mul_b     = b_reg;
  assign out_valid = (state_reg == DRAIN);
  assign out_data  = out_valid ? mul_product[cnt_reg] : '0;
  assign out_last  = out_valid && cnt_end;
  assign out_id    = id_reg;
  assign busy      = (state_reg != IDLE);
  assign err       = err_reg;
endmodule

// File: tb/tb_e_mul_sched.sv
// Directed bench for e_mul_sched with a small behavioural multiplier (WORDS=4, NREQ=2, TIMEOUT=16).
module tb_e_mul_sched;
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       req = '0;
  logic [1:0]       gnt;
  logic [1:0]       in_valid = '0;
  logic [1:0][15:0] in_data = '0;
  logic [1:0]       in_ready;
  logic             mul_start;
  logic [63:0]      mul_a, mul_b;
  logic             mul_done = 1'b0;
  logic [63:0]      prod = '0;
  logic             out_valid;
  logic [15:0]      out_data;
  logic             out_last;
  logic [0:0]       out_id;
  logic             out_ready = 1'b0;
  logic             busy, err;

  int checks = 0;
  int errors = 0;
  int starts = 0;
  bit hang = 1'b0;
  logic [3:0] lat = '0;

  always #5 clk = ~clk;

  e_mul_sched #(.WORDS(4), .NREQ(2), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_product(prod),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_id(out_id), .out_ready(out_ready), .busy(busy), .err(err)
  );

  // Multiplier model: clears done on start, raises it 3 cycles later unless hung.
  always @(posedge clk) begin
    if (mul_start) begin
      starts   <= starts + 1;
      mul_done <= 1'b0;
      prod     <= mul_a * mul_b;
      lat      <= 4'd3;
    end else if (lat != 0) begin
      lat <= lat - 1'b1;
      if (lat == 4'd1 && !hang) mul_done <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ops(input int c, input logic [63:0] a, input logic [63:0] b, input int nwords);
    logic [127:0] ops;
    int n;
    ops = {b, a};
    for (int i = 0; i < nwords; i++) begin
      in_valid[c] = 1'b1;
      in_data[c]  = ops[i*16 +: 16];
      n = 0;
      while (!in_ready[c] && n < 40) begin
        step();
        n++;
      end
      if (n >= 40) chk("in_ready_timeout", {63'd0, in_ready[c]}, 64'd1);
      step();
    end
    in_valid[c] = 1'b0;
  endtask

  task automatic drain(input logic [63:0] exp, input int id, input bit stall);
    logic [3:0] pat;
    int n, idx, cyc;
    pat = 4'b1001;
    n = 0;
    while (!out_valid && n < 60) begin
      step();
      n++;
    end
    chk("drain_start", {63'd0, out_valid}, 64'd1);
    idx = 0;
    cyc = 0;
    while (idx < 4 && cyc < 20) begin
      out_ready = (stall && cyc < 4) ? pat[cyc] : 1'b1;
      chk("out_valid", {63'd0, out_valid}, 64'd1);
      chk($sformatf("out_data%0d", idx), {48'd0, out_data}, {48'd0, exp[idx*16 +: 16]});
      chk($sformatf("out_last%0d", idx), {63'd0, out_last}, {63'd0, idx == 3});
      chk("out_id", {63'd0, out_id}, id);
      if (out_ready && out_valid) idx++;
      step();
      cyc++;
    end
    out_ready = 1'b0;
    chk("words_done", idx, 4);
    chk("idle_after_drain", {63'd0, busy}, 64'd0);
    chk("gnt_after_drain", {62'd0, gnt}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bit seen;

    // Reset state
    step();
    step();
    chk("rst_gnt", {62'd0, gnt}, 0);
    chk("rst_in_ready", {62'd0, in_ready}, 0);
    chk("rst_mul_start", {63'd0, mul_start}, 0);
    chk("rst_out_valid", {63'd0, out_valid}, 0);
    chk("rst_busy", {63'd0, busy}, 0);
    chk("rst_err", {63'd0, err}, 0);
    chk("rst_mul_a", mul_a, 0);
    rst_n = 1'b1;
    step();

    // 1) client0: 3*5, with client1 driving garbage that must be ignored
    req = 2'b01;
    step();
    chk("t1_gnt", {62'd0, gnt}, 64'h1);
    chk("t1_busy", {63'd0, busy}, 1);
    req = 2'b00;
    in_valid[1] = 1'b1;
    in_data[1]  = 16'hDEAD;
    chk("t1_in_ready1", {63'd0, in_ready[1]}, 0);
    load_ops(0, 64'h3, 64'h5, 8);
    chk("t1_start_pulse", {63'd0, mul_start}, 1);
    in_valid[1] = 1'b0;
    chk("t1_mul_a", mul_a, 64'h3);
    chk("t1_mul_b", mul_b, 64'h5);
    drain(64'h000F, 0, 1'b0);
    chk("t1_starts", starts, 1);

    // 2) client1: FFFF*FFFF
    req = 2'b10;
    step();
    chk("t2_gnt", {62'd0, gnt}, 64'h2);
    req = 2'b00;
    load_ops(1, 64'hFFFF, 64'hFFFF, 8);
    drain(64'h0000_0000_FFFE_0001, 1, 1'b0);
    chk("t2_starts", starts, 2);
    chk("t2_mul_a_held", mul_a, 64'hFFFF);

    // 3) both request together across three jobs
    req = 2'b11;
    step();
    chk("t3_gnt_a", {62'd0, gnt}, 64'h1);
    load_ops(0, 64'h2, 64'h3, 8);
    drain(64'h6, 0, 1'b0);
    step();
    chk("t3_gnt_b", {62'd0, gnt}, 64'h2);
    load_ops(1, 64'h4, 64'h5, 8);
    drain(64'h14, 1, 1'b0);
    step();
    chk("t3_gnt_c", {62'd0, gnt}, 64'h1);
    req = 2'b00;
    load_ops(0, 64'h100, 64'h100, 8);
    drain(64'h0000_0000_0001_0000, 0, 1'b0);

    // 4) backpressure 1,0,0,1 during drain
    req = 2'b01;
    step();
    chk("t4_gnt", {62'd0, gnt}, 64'h1);
    req = 2'b00;
    load_ops(0, 64'h0001_0002, 64'h3, 8);
    drain(64'h0003_0006, 0, 1'b1);

    // 5) multiplier never finishes
    hang = 1'b1;
    req = 2'b10;
    step();
    chk("t5_gnt", {62'd0, gnt}, 64'h2);
    req = 2'b00;
    load_ops(1, 64'h9, 64'h9, 8);
    chk("t5_err_before", {63'd0, err}, 0);
    cyc = 0;
    seen = 1'b0;
    while (busy && cyc < 40) begin
      step();
      cyc++;
      if (out_valid) seen = 1'b1;
    end
    chk("t5_abort_cycles", cyc, 17);
    chk("t5_no_output", {63'd0, seen}, 0);
    chk("t5_err", {63'd0, err}, 1);
    chk("t5_gnt_clear", {62'd0, gnt}, 0);
    hang = 1'b0;
    req = 2'b01;
    step();
    chk("t5_next_gnt", {62'd0, gnt}, 64'h1);
    req = 2'b00;
    load_ops(0, 64'h7, 64'h8, 8);
    drain(64'h38, 0, 1'b0);
    chk("t5_err_sticky", {63'd0, err}, 1);

    // 6) reset in the middle of LOAD_B
    req = 2'b01;
    step();
    req = 2'b00;
    load_ops(0, 64'hAA, 64'h55, 6);
    chk("t6_busy_pre", {63'd0, busy}, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_gnt", {62'd0, gnt}, 0);
    chk("t6_in_ready", {62'd0, in_ready}, 0);
    chk("t6_busy", {63'd0, busy}, 0);
    chk("t6_err", {63'd0, err}, 0);
    chk("t6_out_valid", {63'd0, out_valid}, 0);
    chk("t6_out_data", {48'd0, out_data}, 0);
    chk("t6_mul_a", mul_a, 0);
    chk("t6_mul_b", mul_b, 0);
    step();
    rst_n = 1'b1;
    step();
    req = 2'b10;
    step();
    chk("t6_gnt_after", {62'd0, gnt}, 64'h2);
    req = 2'b00;
    load_ops(1, 64'h7, 64'h6, 8);
    drain(64'h2A, 1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
